// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash values, iteration encodings, sigma functions.
// Latency: none (package only).
// Backpressure: not applicable.
package sha256_pkg;

    // Iteration counter encodings shared with the round datapath.
    // Values 0..63 are round indices.
    localparam logic [6:0] ITER_NOP  = 7'd64;
    localparam logic [6:0] ITER_HOLD = 7'd65;

    // Message schedule controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Initial hash values H0..H7.
    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants K[0..63].
    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Small sigma functions of the message schedule.
    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant ROM: registered lookup of K[addr].
// Latency: 1 cycle from addr/en to k.
// Backpressure: none; en freezes the output so it can hold alongside w.
//
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-low; clears k
//   en   - load K[addr] into the output register
//   addr - round index 0..63
//   k    - registered round constant
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  addr,
    output logic [31:0] k
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            k <= 32'h0;
        end else if (en) begin
            k <= K_TABLE[addr];
        end
    end

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: takes one padded 512-bit block, streams W[t] and K[t] one pair per clock.
// Latency: W0/K0 one cycle after accept; done pulse ROUNDS+2 cycles after accept.
// Backpressure: block_ready low while a block is in flight; upstream holds block_in/block_valid.
//
// Ports:
//   clk               - clock
//   rst               - synchronous reset, active-low; returns to IDLE from any state
//   block_in          - padded block, word 0 in [511:480]
//   block_valid       - block_in valid
//   block_ready       - high in IDLE or DONE (combinational from state)
//   padding_done      - start qualifier for the round datapath, set on first accept
//   counter_iteration - 0..63 round, 64 no-op, 65 hold
//   w, k              - schedule word and round constant for counter_iteration
//   sched_valid       - counter_iteration is a round index
//   done              - single-cycle pulse on entry to the hold encoding
module sha256_message_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] block_in,
    input  logic         block_valid,
    output logic         block_ready,
    output logic         padding_done,
    output logic [6:0]   counter_iteration,
    output logic [31:0]  w,
    output logic [31:0]  k,
    output logic         sched_valid,
    output logic         done
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    sched_state_t state;

    // win[j] holds W[t+j] while counter_iteration shows t.
    logic [31:0] win [16];
    logic [31:0] win_next_word;
    logic        accept;
    logic        last_round;
    logic        rom_en;
    logic [5:0]  rom_addr;

    assign block_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign accept      = block_valid && block_ready;
    assign last_round  = (counter_iteration == LAST_ROUND);

    // W[t+16] from the current window; the same recurrence covers t<16
    // because the first 16 words are already in the window at accept.
    assign win_next_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    // The ROM is one address ahead so its registered output lines up with w.
    // It freezes after the last round so k holds through FLUSH/DONE.
    assign rom_en   = accept || ((state == ST_RUN) && !last_round);
    assign rom_addr = accept ? 6'd0 : (counter_iteration[5:0] + 6'd1);

    sha256_k_rom u_k_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (rom_en),
        .addr (rom_addr),
        .k    (k)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= ST_IDLE;
            counter_iteration <= 7'd0;
            w                 <= 32'h0;
            sched_valid       <= 1'b0;
            done              <= 1'b0;
            padding_done      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state             <= ST_RUN;
                        counter_iteration <= 7'd0;
                        w                 <= block_in[511:480];
                        sched_valid       <= 1'b1;
                        padding_done      <= 1'b1;
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block_in[511 - 32*i -: 32];
                        end
                    end
                end
                ST_RUN: begin
                    if (last_round) begin
                        // w and k keep the final round's values.
                        state             <= ST_FLUSH;
                        counter_iteration <= ITER_NOP;
                        sched_valid       <= 1'b0;
                    end else begin
                        counter_iteration <= counter_iteration + 7'd1;
                        w                 <= win[1];
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= win_next_word;
                    end
                end
                ST_FLUSH: begin
                    state             <= ST_DONE;
                    counter_iteration <= ITER_HOLD;
                    done              <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Directed bench for sha256_message_schedule: "abc" and random blocks, reset mid-run, held valid.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: block_valid held high across a block to exercise block_ready.
module tb_sha256_message_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic         padding_done;
    logic [6:0]   counter_iteration;
    logic [31:0]  w;
    logic [31:0]  k;
    logic         sched_valid;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [31:0]  kref [64];
    logic [31:0]  wexp [64];
    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;

    always #5 clk = ~clk;

    sha256_message_schedule #(.ROUNDS(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .block_in          (block_in),
        .block_valid       (block_valid),
        .block_ready       (block_ready),
        .padding_done      (padding_done),
        .counter_iteration (counter_iteration),
        .w                 (w),
        .k                 (k),
        .sched_valid       (sched_valid),
        .done              (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 schedule expansion.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) wexp[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3);
            s1 = rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10);
            wexp[t] = s1 + wexp[t-7] + s0 + wexp[t-16];
        end
    endtask

    // Accept blk, then compare all 64 W/K pairs against the model.
    task automatic run_full(input string name, input logic [511:0] blk);
        build_model(blk);
        block_in    = blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            check($sformatf("%s_ctr_t%0d", name, t), 32'(counter_iteration), 32'(t));
            check($sformatf("%s_w_t%0d", name, t), w, wexp[t]);
            check($sformatf("%s_k_t%0d", name, t), k, kref[t]);
            tick();
        end
        check({name, "_ctr64"}, 32'(counter_iteration), 32'd64);
        tick();
        check({name, "_ctr65"}, 32'(counter_iteration), 32'd65);
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int n;
        logic [6:0] exp_ctr;

        kref = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};

        // Reset state
        rst         = 1'b0;
        block_valid = 1'b0;
        block_in    = '0;
        tick();
        tick();
        check("rst_ctr", 32'(counter_iteration), 32'd0);
        check("rst_w", w, 32'h0);
        check("rst_k", k, 32'h0);
        check("rst_sched_valid", 32'(sched_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_padding_done", 32'(padding_done), 32'd0);
        check("rst_ready", 32'(block_ready), 32'd1);
        rst = 1'b1;
        tick();

        // "abc" block with hand-computed checkpoints
        block_in    = abc_blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        check("abc_w0", w, 32'h61626380);
        check("abc_k0", k, 32'h428a2f98);
        check("abc_sched_valid0", 32'(sched_valid), 32'd1);
        check("abc_padding_done", 32'(padding_done), 32'd1);
        check("abc_ready_run", 32'(block_ready), 32'd0);
        for (int t = 1; t < 64; t++) begin
            tick();
            if (t == 15) check("abc_w15", w, 32'h00000018);
            if (t == 16) check("abc_w16", w, 32'h61626380);
            if (t == 17) check("abc_w17", w, 32'h000f0000);
        end
        check("abc_ctr63", 32'(counter_iteration), 32'd63);
        check("abc_k63", k, 32'hc67178f2);
        tick();
        check("abc_ctr64", 32'(counter_iteration), 32'd64);
        check("abc_sched_valid64", 32'(sched_valid), 32'd0);
        check("abc_k_hold64", k, 32'hc67178f2);
        check("abc_done64", 32'(done), 32'd0);
        tick();
        check("abc_ctr65", 32'(counter_iteration), 32'd65);
        check("abc_ready_done", 32'(block_ready), 32'd1);
        done_cnt = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            check($sformatf("abc_ctr_hold%0d", i), 32'(counter_iteration), 32'd65);
        end
        check("abc_done_pulses", 32'(done_cnt), 32'd1);
        check("abc_padding_done_held", 32'(padding_done), 32'd1);

        // Full comparisons against the model
        run_full("abcfull", abc_blk);
        for (int i = 0; i < 16; i++) rnd_blk[511 - 32*i -: 32] = $urandom();
        run_full("rnd", rnd_blk);

        // Reset mid-block at iteration 30
        block_in    = rnd_blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_ctr30", 32'(counter_iteration), 32'd30);
        rst = 1'b0;
        tick();
        check("mid_rst_ctr", 32'(counter_iteration), 32'd0);
        check("mid_rst_w", w, 32'h0);
        check("mid_rst_k", k, 32'h0);
        check("mid_rst_sched_valid", 32'(sched_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_padding_done", 32'(padding_done), 32'd0);
        check("mid_rst_ready", 32'(block_ready), 32'd1);
        rst         = 1'b1;
        block_in    = abc_blk;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        check("restart_ctr", 32'(counter_iteration), 32'd0);
        check("restart_w0", w, 32'h61626380);
        check("restart_k0", k, 32'h428a2f98);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("restart_done_reached", 32'(done), 32'd1);

        // block_valid held high: one accept per block, no gap after DONE
        build_model(abc_blk);
        block_valid = 1'b1;
        tick();
        exp_ctr = 7'd0;
        for (int i = 0; i < 132; i++) begin
            check($sformatf("held_ctr_%0d", i), 32'(counter_iteration), 32'(exp_ctr));
            check($sformatf("held_ready_%0d", i), 32'(block_ready), (exp_ctr == 7'd65) ? 32'd1 : 32'd0);
            if (exp_ctr < 7'd64) check($sformatf("held_w_%0d", i), w, wexp[exp_ctr[5:0]]);
            exp_ctr = (exp_ctr == 7'd65) ? 7'd0 : exp_ctr + 7'd1;
            tick();
        end

        // block_valid high while in reset is ignored
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstvld_ctr_%0d", i), 32'(counter_iteration), 32'd0);
            check($sformatf("rstvld_sched_valid_%0d", i), 32'(sched_valid), 32'd0);
        end
        rst         = 1'b1;
        block_valid = 1'b0;
        tick();
        tick();
        check("rstvld_idle_ctr", 32'(counter_iteration), 32'd0);
        check("rstvld_idle_sched_valid", 32'(sched_valid), 32'd0);
        check("rstvld_idle_padding_done", 32'(padding_done), 32'd0);
        check("rstvld_idle_ready", 32'(block_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
